// File: rtl/lane_memory.sv
// -----------------------------------------------------------------------------
// lane_memory
//
// Byte-lane data memory sitting between a load/store unit and on-chip block
// RAM. A request of 1, 2, 4 or 8 bytes at any byte address is served in one
// RAM access: the row is split across LANES independent 8-bit banks, and each
// lane picks its own row so an unaligned access may straddle two rows.
// Responses arrive one cycle after acceptance with a valid/ready handshake.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   request present
//   req_ready   request can be accepted this cycle (combinational)
//   req_addr    byte address of the lowest byte
//   req_size    0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B
//   req_write   1 = store, 0 = load
//   req_signed  sign-extend (1) or zero-extend (0) the load result
//   req_wdata   store data, little-endian, low size bytes used
//   resp_valid  response present
//   resp_ready  consumer takes the response
//   resp_rdata  load data, or the pre-store contents for a store
//   resp_fault  request was out of range or too wide; no memory effect
// -----------------------------------------------------------------------------
module lane_memory #(
  parameter int LANES      = 4,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_write,
  input  logic                  req_signed,
  input  logic [LANES*8-1:0]    req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [LANES*8-1:0]    resp_rdata,
  output logic                  resp_fault
);

  localparam int LB = $clog2(LANES);
  localparam int RW = $clog2(DEPTH);
  localparam int DW = LANES * 8;
  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(LANES * DEPTH);

  // Rotate the per-lane read bytes so that data byte k comes from lane
  // (k + off) mod LANES; the modulo falls out of LB-bit wrap-around.
  function automatic logic [DW-1:0] rotate_lanes(
    input logic [LANES-1:0][7:0] lanes,
    input logic [LB-1:0]         off
  );
    logic [LANES-1:0][7:0] bytes;
    logic [LB-1:0]         src;
    for (int k = 0; k < LANES; k++) begin
      src      = LB'(k) + off;
      bytes[k] = lanes[src];
    end
    return bytes;
  endfunction

  // Replace bytes at or above n with the fill byte: copies of bit 7 of byte
  // n-1 for signed loads, zero otherwise. A full-width access is untouched.
  function automatic logic [DW-1:0] extend_bytes(
    input logic [DW-1:0] data,
    input logic [3:0]    n,
    input logic          sgn
  );
    logic [LANES-1:0][7:0] bytes;
    logic [LB-1:0]         top;
    logic                  fill;
    bytes = data;
    top   = LB'(n - 4'd1);
    fill  = sgn & bytes[top][7];
    for (int k = 0; k < LANES; k++) begin
      if (4'(k) >= n) bytes[k] = {8{fill}};
    end
    return bytes;
  endfunction

  logic                  accept;
  logic [3:0]            n_p0;
  logic [LB-1:0]         off_p0;
  logic [RW-1:0]         row_p0;
  logic [ADDR_WIDTH:0]   end_p0;
  logic                  fault_p0;
  logic [LANES-1:0]      lane_en_p0;
  logic [LANES-1:0]      bank_en_p0;
  logic [LANES-1:0]      bank_we_p0;
  logic [LANES-1:0][RW-1:0] lane_row_p0;
  logic [LANES-1:0][7:0] lane_wd_p0;
  logic [LANES-1:0][7:0] lane_rd_p1;

  logic [LB-1:0]         off_p1;
  logic [3:0]            n_p1;
  logic                  sgn_p1;
  logic                  fault_p1;

  // ---- stage p0: request decode and lane mapping ----
  // A stalled response blocks acceptance, which also gates every bank enable
  // so the registered read bytes hold for the whole stall.
  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;

  assign n_p0   = 4'd1 << req_size;
  assign off_p0 = req_addr[LB-1:0];
  assign row_p0 = req_addr[LB +: RW];
  // One extra bit so an access near the top of the address space cannot wrap
  // around and look legal.
  assign end_p0   = {1'b0, req_addr} + (ADDR_WIDTH+1)'(n_p0);
  assign fault_p0 = (n_p0 > 4'(LANES)) || (end_p0 > CAP);

  always_comb begin
    lane_en_p0  = '0;
    lane_row_p0 = '0;
    lane_wd_p0  = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [LB-1:0] lane_id;
      logic [LB-1:0] byte_idx;
      lane_id  = LB'(l);
      byte_idx = lane_id - off_p0;
      // Lanes below the offset hold the tail of the access, which lives in
      // the next row. For the last row that row wraps, but such an access
      // always faults and never reaches the banks.
      lane_row_p0[l] = (lane_id < off_p0) ? row_p0 + RW'(1) : row_p0;
      lane_en_p0[l]  = 4'(byte_idx) < n_p0;
      lane_wd_p0[l]  = req_wdata[{byte_idx, 3'b000} +: 8];
    end
  end

  assign bank_en_p0 = lane_en_p0 & {LANES{accept && !fault_p0}};
  assign bank_we_p0 = bank_en_p0 & {LANES{req_write}};

  // ---- stage p0 -> p1: read-first byte banks ----
  for (genvar g = 0; g < LANES; g++) begin : g_bank
    logic [7:0] ram [DEPTH];
    logic [7:0] rd_p1;

    always_ff @(posedge clk) begin
      if (bank_en_p0[g]) begin
        if (bank_we_p0[g]) ram[lane_row_p0[g]] <= lane_wd_p0[g];
        rd_p1 <= ram[lane_row_p0[g]];
      end
    end

    assign lane_rd_p1[g] = rd_p1;
  end

  // ---- stage p0 -> p1: response control ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      fault_p1   <= 1'b0;
      off_p1     <= '0;
      n_p1       <= 4'd1;
      sgn_p1     <= 1'b0;
    end else begin
      if (accept) begin
        resp_valid <= 1'b1;
        fault_p1   <= fault_p0;
        off_p1     <= off_p0;
        n_p1       <= n_p0;
        sgn_p1     <= req_signed;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // ---- stage p1: response assembly ----
  // Gating with resp_valid gives zero data while idle and right after reset,
  // without having to reset the bank read registers.
  assign resp_rdata = (resp_valid && !fault_p1)
                    ? extend_bytes(rotate_lanes(lane_rd_p1, off_p1), n_p1, sgn_p1)
                    : '0;
  assign resp_fault = resp_valid && fault_p1;

endmodule

// File: tb/tb_lane_memory.sv
module tb_lane_memory;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_write;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  lane_memory #(.LANES(4), .DEPTH(16), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_write  (req_write),
    .req_signed (req_signed),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    bit          chk;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          resp_cyc[$];
  int          cyc = 0;
  int          tests_run = 0;
  int          failures = 0;
  logic [7:0]  m [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: a response is taken at the next rising edge whenever
  // resp_valid && resp_ready, so it is checked on the falling edge before.
  always @(negedge clk) begin
    if (rst === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      exp_t e;
      tests_run++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_resp: observed data=%h fault=%b expected no response", resp_rdata, resp_fault);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        resp_cyc.push_back(cyc);
        if (e.chk) begin
          tests_run++;
          assert (resp_rdata === e.data && resp_fault === e.fault) else begin
            failures++;
            $error("FAIL %s: observed data=%h fault=%b expected data=%h fault=%b",
                   e.tag, resp_rdata, resp_fault, e.data, e.fault);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed reference model: computes the response and applies the
  // store, then queues the expectation (or the explicit one given).
  task automatic predict(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                         input logic sg, input logic [31:0] wd, input string tag,
                         input bit use_exp, input logic [31:0] xd, input logic xf,
                         input bit check);
    int          n;
    logic        f;
    logic [31:0] r;
    exp_t        e;
    n = 1 << sz;
    f = (n > 4) || (longint'(a) + n > 64);
    r = '0;
    if (!f) begin
      for (int k = 0; k < n; k++) r[8*k +: 8] = m[a + k];
      for (int k = n; k < 4; k++) r[8*k +: 8] = (sg && m[a + n - 1][7]) ? 8'hFF : 8'h00;
      if (wr) for (int k = 0; k < n; k++) m[a + k] = wd[8*k +: 8];
    end
    e.data  = use_exp ? xd : r;
    e.fault = use_exp ? xf : f;
    e.chk   = check;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                       input logic sg, input logic [31:0] wd);
    int w = 0;
    while (req_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = sz;
    req_write  = wr;
    req_signed = sg;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                      input logic sg, input logic [31:0] wd, input string tag,
                      input bit use_exp = 0, input logic [31:0] xd = 0,
                      input logic xf = 0, input bit check = 1);
    predict(a, sz, wr, sg, wd, tag, use_exp, xd, xf, check);
    drive(a, sz, wr, sg, wd);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_size   = '0;
    req_write  = 1'b0;
    req_signed = 1'b0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    rst        = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_fault", 64'(resp_fault), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Clear all 16 rows; old contents are unknown so those responses are
    // consumed without a data check.
    for (int i = 0; i < 16; i++) send(32'(i * 4), 2'd2, 1'b1, 1'b0, 32'h0, "clear", 0, 0, 0, 0);

    // Signed / unsigned half load
    send(32'h0, 2'd2, 1'b1, 1'b0, 32'h80FF7F01, "st_80ff7f01");
    send(32'h1, 2'd1, 1'b0, 1'b1, 32'h0, "ld_half_s", 1, 32'hFFFFFF7F, 1'b0);
    send(32'h1, 2'd1, 1'b0, 1'b0, 32'h0, "ld_half_u", 1, 32'h0000FF7F, 1'b0);
    send(32'h2, 2'd0, 1'b0, 1'b1, 32'h0, "ld_byte_s_ff", 1, 32'hFFFFFFFF, 1'b0);
    send(32'h0, 2'd0, 1'b0, 1'b1, 32'h0, "ld_byte_s_01", 1, 32'h00000001, 1'b0);
    send(32'h0, 2'd2, 1'b0, 1'b1, 32'h0, "ld_word_s", 1, 32'h80FF7F01, 1'b0);

    // Unaligned store crossing a row boundary
    send(32'h6, 2'd2, 1'b1, 1'b0, 32'hAABBCCDD, "st_unaligned");
    send(32'h8, 2'd2, 1'b0, 1'b0, 32'h0, "ld_word_8", 1, 32'h0000AABB, 1'b0);
    send(32'h4, 2'd2, 1'b0, 1'b0, 32'h0, "ld_word_4", 1, 32'hCCDD0000, 1'b0);
    send(32'h6, 2'd2, 1'b0, 1'b0, 32'h0, "ld_word_6", 1, 32'hAABBCCDD, 1'b0);

    // Faults and the last legal bytes
    send(32'h3E, 2'd2, 1'b0, 1'b0, 32'h0, "fault_ld_3e", 1, 32'h0, 1'b1);
    send(32'h3E, 2'd2, 1'b1, 1'b0, 32'h11223344, "fault_st_3e", 1, 32'h0, 1'b1);
    send(32'h0, 2'd3, 1'b0, 1'b0, 32'h0, "fault_size3", 1, 32'h0, 1'b1);
    send(32'h3F, 2'd1, 1'b0, 1'b0, 32'h0, "fault_half_3f", 1, 32'h0, 1'b1);
    send(32'h3C, 2'd2, 1'b0, 1'b0, 32'h0, "ld_word_3c", 1, 32'h0, 1'b0);
    send(32'h3F, 2'd0, 1'b0, 1'b0, 32'h0, "ld_byte_3f", 1, 32'h0, 1'b0);
    send(32'h3C, 2'd2, 1'b1, 1'b0, 32'h55667788, "st_word_3c", 1, 32'h0, 1'b0);
    send(32'h3E, 2'd1, 1'b0, 1'b1, 32'h0, "ld_half_3e_s", 1, 32'h00005566, 1'b0);

    // Store returns old data
    send(32'h10, 2'd2, 1'b1, 1'b0, 32'hDEADBEEF, "st_deadbeef");
    send(32'h10, 2'd2, 1'b1, 1'b0, 32'h12345678, "st_old_data", 1, 32'hDEADBEEF, 1'b0);
    send(32'h10, 2'd2, 1'b0, 1'b0, 32'h0, "ld_12345678", 1, 32'h12345678, 1'b0);
    drain();

    // Backpressure: response held for 3 cycles while another request waits
    resp_ready = 1'b0;
    send(32'h10, 2'd2, 1'b0, 1'b0, 32'h0, "stall_a", 1, 32'h12345678, 1'b0);
    predict(32'h6, 2'd2, 1'b0, 1'b0, 32'h0, "stall_b", 1, 32'hAABBCCDD, 1'b0, 1);
    req_valid  = 1'b1;
    req_addr   = 32'h6;
    req_size   = 2'd2;
    req_write  = 1'b0;
    req_signed = 1'b0;
    req_wdata  = '0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_rdata", 64'(resp_rdata), 64'h12345678);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    // Streaming: four back-to-back loads
    n0 = resp_cyc.size();
    send(32'h0, 2'd2, 1'b0, 1'b0, 32'h0, "stream0", 1, 32'h80FF7F01, 1'b0);
    send(32'h4, 2'd2, 1'b0, 1'b0, 32'h0, "stream1", 1, 32'hCCDD0000, 1'b0);
    send(32'h9, 2'd0, 1'b0, 1'b1, 32'h0, "stream2", 1, 32'hFFFFFFAA, 1'b0);
    send(32'h12, 2'd1, 1'b0, 1'b0, 32'h0, "stream3", 1, 32'h00001234, 1'b0);
    drain();
    chk("stream_count", 64'(resp_cyc.size() - n0), 64'd4);
    if (resp_cyc.size() >= n0 + 4)
      chk("stream_consecutive", 64'(resp_cyc[n0+3] - resp_cyc[n0]), 64'd3);

    // Asynchronous reset while a response is stalled
    resp_ready = 1'b0;
    drive(32'h10, 2'd2, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("pre_rst_valid", 64'(resp_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(resp_valid), 64'd0);
    chk("async_rst_rdata", 64'(resp_rdata), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    send(32'h10, 2'd2, 1'b0, 1'b0, 32'h0, "ld_after_rst", 1, 32'h12345678, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
